// File: rtl/rv_decode_stage.sv
// rv_decode_stage: RV32I integer-ALU decode/issue stage.
// Two-entry elastic output buffer (OUT + SKID) with registered in_ready.
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic            wb_en;
    logic            illegal;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } st_t;

  st_t  st_q;
  st_t  st_nx;
  logic rdy_q;
  ent_t out_q;
  ent_t skid_q;
  ent_t dec;

  logic ld_out;
  logic ld_skid;
  logic out_from_skid;
  logic acc;
  logic ret;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_sh;
  logic [XLEN-1:0] imm_u;
  logic            is_op;
  logic            is_imm;
  logic            is_lui;
  logic            is_auipc;
  logic            op_ok;
  logic            imm_ok;
  logic            alt;

  function automatic logic [3:0] f3_op(
    input logic [2:0] fn3,
    input logic       a
  );
    logic [3:0] r;
    r = ALU_ADD;
    unique case (fn3)
      3'b000: r = a ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = a ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_sh = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};

  assign is_op    = (opc == OPC_OP);
  assign is_imm   = (opc == OPC_IMM);
  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);

  assign op_ok = (f7 == F7_ZERO) ||
                 ((f7 == F7_ALT) &&
                  ((f3 == 3'b000) || (f3 == 3'b101)));

  assign imm_ok = (f3 == 3'b001) ? (f7 == F7_ZERO) :
                  (f3 == 3'b101) ? ((f7 == F7_ZERO) ||
                                    (f7 == F7_ALT)) :
                  1'b1;

  assign alt = (f7 == F7_ALT);

  // Decode the incoming instruction into an ALU entry.
  always_comb begin
    dec    = '0;
    dec.rd = in_instr[11:7];
    unique case (1'b1)
      is_op && op_ok: begin
        dec.op1    = in_rs1_data;
        dec.op2    = in_rs2_data;
        dec.alu_op = f3_op(f3, alt);
      end
      is_imm && imm_ok: begin
        dec.op1    = in_rs1_data;
        dec.op2    = (f3 == 3'b001 || f3 == 3'b101)
                     ? imm_sh : imm_i;
        dec.alu_op = f3_op(f3, alt && (f3 == 3'b101));
      end
      is_lui: begin
        dec.op2 = imm_u;
      end
      is_auipc: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.wb_en = !dec.illegal && (dec.rd != 5'd0);
  end

  assign out_valid = (st_q != EMPTY);
  assign in_ready  = rdy_q;
  assign acc       = in_valid && rdy_q;
  assign ret       = out_valid && out_ready;

  // Occupancy next-state and buffer load controls.
  always_comb begin
    st_nx         = st_q;
    ld_out        = 1'b0;
    ld_skid       = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      st_nx = EMPTY;
    end else begin
      unique case (st_q)
        EMPTY: begin
          if (acc) begin
            st_nx  = ONE;
            ld_out = 1'b1;
          end
        end
        ONE: begin
          if (acc && ret) begin
            ld_out = 1'b1;
          end else if (acc) begin
            st_nx   = TWO;
            ld_skid = 1'b1;
          end else if (ret) begin
            st_nx = EMPTY;
          end
        end
        TWO: begin
          if (ret) begin
            st_nx         = ONE;
            ld_out        = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: begin
          st_nx = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      st_q  <= st_nx;
      rdy_q <= (st_nx != TWO);
    end
  end

  // OUT and SKID data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out)
        out_q <= out_from_skid ? skid_q : dec;
      if (ld_skid)
        skid_q <= dec;
    end
  end

  assign out_op1     = out_q.op1;
  assign out_op2     = out_q.op2;
  assign out_alu_op  = out_q.alu_op;
  assign out_rd      = out_q.rd;
  assign out_wb_en   = out_q.wb_en;
  assign out_illegal = out_q.illegal;

endmodule
